// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the T-cell up/down counter.
package counter_pkg;

   localparam int unsigned MIN_WIDTH = 2;
   localparam int unsigned MAX_WIDTH = 16;
   localparam int unsigned MIN_MOD   = 2;

   // True when width and modulus describe a buildable counter.
   function automatic bit range_ok(input int unsigned width, input int unsigned mod);
      return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
             (mod >= MIN_MOD) && (mod <= (32'd1 << width));
   endfunction

   // Terminal count value, truncated to the counter width.
   function automatic int unsigned mod_max(input int unsigned mod, input int unsigned width);
      return (mod - 32'd1) & ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: the stored bit flips whenever t is high on a rising edge.
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (reset) q <= 1'b0;
      else       q <= q ^ t;
   end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MOD up/down counter: builds the toggle mask that drives a bank of T cells,
// plus the load clamp, terminal-count pulse and sticky wrap flag.
module tff_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_wrap,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(mod_max(MOD, WIDTH));

   if (!range_ok(WIDTH, MOD)) begin : g_bad_params
      $error("tff_updown_counter: WIDTH must be 2..16 and MOD 2..2**WIDTH");
   end

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] inc_mask;
   logic [WIDTH-1:0] dec_mask;
   logic [WIDTH-1:0] load_clamped;
   logic             carry;
   logic             borrow;
   logic             tc_next;
   logic             wrap_set;

   // Toggle mask selection: load > count > hold (reset acts inside the cells).
   always_comb begin
      t        = '0;
      inc_mask = '0;
      dec_mask = '0;
      carry    = 1'b1;
      borrow   = 1'b1;
      tc_next  = 1'b0;
      wrap_set = 1'b0;

      for (int i = 0; i < int'(WIDTH); i++) begin
         inc_mask[i] = carry;
         dec_mask[i] = borrow;
         carry       = carry & q[i];
         borrow      = borrow & ~q[i];
      end

      load_clamped = (load_val > MAX) ? MAX : load_val;

      if (load) begin
         t = q ^ load_clamped;
      end else if (en) begin
         if (up) begin
            // Anything at or above MAX is terminal, so a corrupted q recovers to 0.
            if (q >= MAX) begin
               t        = q;
               tc_next  = 1'b1;
               wrap_set = 1'b1;
            end else begin
               t = inc_mask;
            end
         end else begin
            if (q == '0) begin
               t        = q ^ MAX;
               tc_next  = 1'b1;
               wrap_set = 1'b1;
            end else begin
               t = dec_mask;
            end
         end
      end
   end

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      tff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .t     (t[i]),
         .q     (q[i])
      );
   end

   // A wrap in the same cycle as clr_wrap leaves the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         tc      <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         tc      <= tc_next;
         wrapped <= wrap_set | (wrapped & ~clr_wrap);
      end
   end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed vector bench for two counter configurations: 4-bit mod-10 and 3-bit mod-8.
module tb_tff_updown_counter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset, a_en, a_up, a_load, a_clr;
   logic [3:0] a_load_val, a_q;
   logic       a_tc, a_wrapped;

   logic       b_reset, b_en, b_up, b_load, b_clr;
   logic [2:0] b_load_val, b_q;
   logic       b_tc, b_wrapped;

   tff_updown_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
      .clk      (clk),
      .reset    (a_reset),
      .en       (a_en),
      .up       (a_up),
      .load     (a_load),
      .load_val (a_load_val),
      .clr_wrap (a_clr),
      .q        (a_q),
      .tc       (a_tc),
      .wrapped  (a_wrapped)
   );

   tff_updown_counter #(.WIDTH(3), .MOD(8)) u_dut_b (
      .clk      (clk),
      .reset    (b_reset),
      .en       (b_en),
      .up       (b_up),
      .load     (b_load),
      .load_val (b_load_val),
      .clr_wrap (b_clr),
      .q        (b_q),
      .tc       (b_tc),
      .wrapped  (b_wrapped)
   );

   typedef struct {
      bit       sel;       // 0: mod-10 counter, 1: mod-8 counter
      bit       rst;
      bit       en;
      bit       up;
      bit       ld;
      bit [3:0] lv;
      bit       clr;
      bit [3:0] eq;
      bit       etc;
      bit       ew;
   } vec_t;

   vec_t vq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic add(input bit sel, input bit rst, input bit en, input bit up,
                      input bit ld, input bit [3:0] lv, input bit clr,
                      input bit [3:0] eq, input bit etc, input bit ew);
      vec_t v;
      v.sel = sel; v.rst = rst; v.en = en; v.up = up; v.ld = ld;
      v.lv = lv; v.clr = clr; v.eq = eq; v.etc = etc; v.ew = ew;
      vq.push_back(v);
   endtask

   task automatic idle_all();
      a_reset = 0; a_en = 0; a_up = 0; a_load = 0; a_load_val = '0; a_clr = 0;
      b_reset = 0; b_en = 0; b_up = 0; b_load = 0; b_load_val = '0; b_clr = 0;
   endtask

   // Apply one vector for one edge, then compare outputs 1 time unit after the edge.
   task automatic apply(input vec_t v, input string name);
      logic [3:0] gq;
      logic       gtc, gw;
      idle_all();
      if (!v.sel) begin
         a_reset = v.rst; a_en = v.en; a_up = v.up; a_load = v.ld;
         a_load_val = v.lv; a_clr = v.clr;
      end else begin
         b_reset = v.rst; b_en = v.en; b_up = v.up; b_load = v.ld;
         b_load_val = 3'(v.lv); b_clr = v.clr;
      end
      @(posedge clk);
      #1;
      gq  = v.sel ? {1'b0, b_q} : a_q;
      gtc = v.sel ? b_tc : a_tc;
      gw  = v.sel ? b_wrapped : a_wrapped;
      tests++;
      if (gq !== v.eq || gtc !== v.etc || gw !== v.ew) begin
         fails++;
         $display("FAIL %s: got q=%0d tc=%0b wrapped=%0b, want q=%0d tc=%0b wrapped=%0b",
                  name, gq, gtc, gw, v.eq, v.etc, v.ew);
      end
   endtask

   initial begin
      idle_all();

      // sel rst en up ld lv clr | q tc w
      add(0,1,0,0,0,0,0, 0,0,0);
      add(0,1,0,0,0,0,0, 0,0,0);
      for (int i = 1; i <= 9; i++) add(0,0,1,1,0,0,0, 4'(i),0,0);
      add(0,0,1,1,0,0,0, 0,1,1);   // 9 -> 0 wrap
      add(0,0,1,1,0,0,0, 1,0,1);   // tc lasts one cycle
      add(0,0,1,0,0,0,0, 0,0,1);   // direction change, same cycle
      add(0,1,0,0,0,0,0, 0,0,0);
      add(0,0,1,0,0,0,0, 9,1,1);   // 0 -> MOD-1 wrap down
      add(0,0,1,0,0,0,0, 8,0,1);
      add(0,0,1,0,0,0,0, 7,0,1);
      add(0,0,1,1,1,13,0, 9,0,1);  // load clamp, load beats en
      add(0,0,0,0,0,0,0, 9,0,1);   // hold
      add(0,0,0,0,1,5,0, 5,0,1);
      add(0,0,1,0,0,0,0, 4,0,1);
      add(0,0,0,0,1,8,0, 8,0,1);
      add(0,0,1,0,0,0,0, 7,0,1);   // 1000 -> 0111 borrow chain
      add(0,0,1,1,0,0,0, 8,0,1);   // 0111 -> 1000 carry chain
      add(0,0,0,0,1,9,1, 9,0,0);   // load with clr_wrap
      add(0,0,1,1,0,0,0, 0,1,1);
      add(0,0,1,1,0,0,1, 1,0,0);   // plain clr during non-wrap count
      add(0,0,0,0,1,9,0, 9,0,0);
      add(0,0,1,1,0,0,1, 0,1,1);   // wrap beats clr_wrap
      add(0,0,0,0,0,0,1, 0,0,0);   // clr_wrap alone
      add(0,0,1,1,1,5,0, 5,0,0);
      add(0,0,1,1,0,0,0, 6,0,0);
      add(0,1,1,1,1,3,0, 0,0,0);   // reset beats load and count
      add(0,0,0,0,0,0,0, 0,0,0);

      add(1,1,0,0,0,0,0, 0,0,0);
      for (int i = 1; i <= 7; i++) add(1,0,1,1,0,0,0, 4'(i),0,0);
      add(1,0,1,1,0,0,0, 0,1,1);   // natural binary overflow
      add(1,0,1,1,0,0,0, 1,0,1);
      add(1,0,0,0,0,0,0, 1,0,1);
      add(1,0,0,0,0,0,0, 1,0,1);
      add(1,0,1,0,0,0,0, 0,0,1);
      add(1,0,1,0,0,0,0, 7,1,1);
      add(1,0,0,0,1,7,0, 7,0,1);
      add(1,0,1,1,0,0,0, 0,1,1);

      foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

      // Back-to-back wraps keep tc high across consecutive cycles.
      begin
         vec_t v;
         v = '{sel:0, rst:1, en:0, up:0, ld:0, lv:0, clr:0, eq:0, etc:0, ew:0};
         apply(v, "seq_reset");
         v = '{sel:0, rst:0, en:1, up:0, ld:0, lv:0, clr:0, eq:9, etc:1, ew:1};
         apply(v, "seq_wrap_down");
         v = '{sel:0, rst:0, en:1, up:1, ld:0, lv:0, clr:0, eq:0, etc:1, ew:1};
         apply(v, "seq_wrap_up");
         v = '{sel:0, rst:0, en:1, up:0, ld:0, lv:0, clr:1, eq:9, etc:1, ew:1};
         apply(v, "seq_wrap_down_clr");
         v = '{sel:0, rst:0, en:0, up:0, ld:0, lv:0, clr:0, eq:9, etc:0, ew:1};
         apply(v, "seq_tc_drop");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
